// File: rtl/operand_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_entry_ctrl_if
//  Brief    : Valid/ready request and single-pulse response bundle to the ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface operand_entry_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_r1;
    logic [DATA_W-1:0] rsp_r2;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_r1, rsp_r2
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_r1, rsp_r2
    );
endinterface
`default_nettype wire

// File: rtl/operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : operand_entry_ctrl
//  Brief    : Debounced, auto-repeating operand/opcode entry from push-buttons,
//             one ALU request per commit, latched result digits.
//  Revision : 1.0  initial release
// ============================================================================
module operand_entry_ctrl #(
    parameter int DATA_W       = 4,
    parameter int DIGIT_MAX    = 9,
    parameter int OP_W         = 2,
    parameter int OP_MAX       = 3,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 10000000
) (
    input  wire                CLOCK_50,
    input  wire                RESET_N,
    input  wire  [3:0]         KEY,
    output logic [DATA_W-1:0]  a_out,
    output logic [DATA_W-1:0]  b_out,
    output logic [OP_W-1:0]    op_out,
    output logic [DATA_W-1:0]  res1,
    output logic [DATA_W-1:0]  res2,
    output logic               res_valid,
    output logic               busy,
    operand_entry_ctrl_if.master alu
);

    localparam int c_DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int c_RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int c_RP_W   = (c_RP_MAX > 1) ? $clog2(c_RP_MAX) : 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_RP_W-1:0] c_DLY_LAST  = c_RP_W'(REPEAT_DLY - 1);
    localparam logic [c_RP_W-1:0] c_PER_LAST  = c_RP_W'(REPEAT_PER - 1);
    localparam logic [DATA_W-1:0] c_DIGIT_MAX = DATA_W'(DIGIT_MAX);
    localparam logic [OP_W-1:0]   c_OP_MAX    = OP_W'(OP_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]        r_key_meta;
    logic [3:0]        r_key_sync;
    logic [3:0]        r_key_acc;     // 1 = released
    logic [3:0]        r_press;
    logic [c_DB_W-1:0] r_db_cnt [4];
    logic [2:0]        w_rep;
    logic [2:0]        w_edit;
    logic              w_commit;
    logic              w_idle;

    logic [DATA_W-1:0] r_a, r_b, r_req_a, r_req_b, r_res1, r_res2;
    logic [OP_W-1:0]   r_op, r_req_op;
    logic              r_req_valid, r_res_valid, r_busy;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key_meta <= '1;
            r_key_sync <= '1;
        end else begin
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
        end
    end

    // Accepted level only moves after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key_acc <= '1;
            r_press   <= '0;
            for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
        end else begin
            r_press <= '0;
            for (int k = 0; k < 4; k++) begin
                if (r_key_sync[k] == r_key_acc[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == c_DB_LAST) begin
                    r_db_cnt[k]  <= '0;
                    r_key_acc[k] <= ~r_key_acc[k];
                    r_press[k]   <= r_key_acc[k];
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rep
            logic [c_RP_W-1:0] r_rp_cnt [3];
            logic [2:0]        r_rp_per;
            logic [2:0]        r_rp_pulse;

            // First repeat after REPEAT_DLY held cycles, then one every REPEAT_PER.
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_rp_per   <= '0;
                    r_rp_pulse <= '0;
                    for (int k = 0; k < 3; k++) r_rp_cnt[k] <= '0;
                end else begin
                    r_rp_pulse <= '0;
                    for (int k = 0; k < 3; k++) begin
                        if (r_key_acc[k]) begin
                            r_rp_cnt[k] <= '0;
                            r_rp_per[k] <= 1'b0;
                        end else if (r_rp_cnt[k] == (r_rp_per[k] ? c_PER_LAST : c_DLY_LAST)) begin
                            r_rp_cnt[k]   <= '0;
                            r_rp_per[k]   <= 1'b1;
                            r_rp_pulse[k] <= 1'b1;
                        end else begin
                            r_rp_cnt[k] <= r_rp_cnt[k] + 1'b1;
                        end
                    end
                end
            end

            assign w_rep = r_rp_pulse;
        end else begin : g_no_rep
            assign w_rep = '0;
        end
    endgenerate

    assign w_edit   = r_press[2:0] | w_rep;
    assign w_commit = r_press[3];
    assign w_idle   = (r_state == S_IDLE);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_commit)                      w_state_nxt = S_REQ;
            S_REQ:   if (r_req_valid && alu.req_ready)  w_state_nxt = S_WAIT;
            S_WAIT:  if (alu.rsp_valid)                 w_state_nxt = S_IDLE;
            default:                                    w_state_nxt = S_IDLE;
        endcase
    end

    // Edits are only honoured in IDLE so the snapshot and result stay coherent.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_req_a     <= '0;
            r_req_b     <= '0;
            r_req_op    <= '0;
            r_req_valid <= 1'b0;
            r_res1      <= '0;
            r_res2      <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_idle) begin
                if (w_edit[2]) r_a  <= (r_a  == c_DIGIT_MAX) ? '0 : r_a  + 1'b1;
                if (w_edit[1]) r_b  <= (r_b  == c_DIGIT_MAX) ? '0 : r_b  + 1'b1;
                if (w_edit[0]) r_op <= (r_op == c_OP_MAX)    ? '0 : r_op + 1'b1;
                if (|w_edit)   r_res_valid <= 1'b0;
                if (w_commit) begin
                    r_req_a  <= r_a;
                    r_req_b  <= r_b;
                    r_req_op <= r_op;
                end
            end
            if (r_state == S_WAIT && alu.rsp_valid) begin
                r_res1      <= alu.rsp_r1;
                r_res2      <= alu.rsp_r2;
                r_res_valid <= 1'b1;
            end
            r_req_valid <= (w_state_nxt == S_REQ);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign a_out         = r_a;
    assign b_out         = r_b;
    assign op_out        = r_op;
    assign res1          = r_res1;
    assign res2          = r_res2;
    assign res_valid     = r_res_valid;
    assign busy          = r_busy;
    assign alu.req_valid = r_req_valid;
    assign alu.req_a     = r_req_a;
    assign alu.req_b     = r_req_b;
    assign alu.req_op    = r_req_op;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_entry_ctrl
//  Brief    : Directed self-checking bench for operand_entry_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic [3:0] a_out, b_out, res1, res2;
    logic [1:0] op_out;
    logic       res_valid, busy;
    int         n_tests = 0;
    int         n_fail  = 0;

    operand_entry_ctrl_if #(.DATA_W(4), .OP_W(2)) alu_if ();

    operand_entry_ctrl #(
        .DATA_W(4), .DIGIT_MAX(9), .OP_W(2), .OP_MAX(3),
        .DEBOUNCE_CYC(4), .REPEAT_EN(1), .REPEAT_DLY(20), .REPEAT_PER(8)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY      (key),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_out   (op_out),
        .res1     (res1),
        .res2     (res2),
        .res_valid(res_valid),
        .busy     (busy),
        .alu      (alu_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        key = 4'hF;
        alu_if.req_ready = 1'b0;
        alu_if.rsp_valid = 1'b0;
        alu_if.rsp_r1    = 4'd0;
        alu_if.rsp_r2    = 4'd0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic press_key(input int idx, input int low);
        key[idx] = 1'b0;
        tick(low);
        key[idx] = 1'b1;
        tick(10);
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (alu_if.req_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({a_out, b_out, op_out} !== 10'd0) begin
            n_fail++; $display("FAIL reset_operands: got %h want 0", {a_out, b_out, op_out});
        end
        n_tests++;
        if ({alu_if.req_valid, alu_if.req_a, alu_if.req_b, alu_if.req_op} !== 11'd0) begin
            n_fail++; $display("FAIL reset_req: got %h want 0",
                {alu_if.req_valid, alu_if.req_a, alu_if.req_b, alu_if.req_op});
        end
        n_tests++;
        if ({res1, res2, res_valid, busy} !== 10'd0) begin
            n_fail++; $display("FAIL reset_res: got %h want 0", {res1, res2, res_valid, busy});
        end
    endtask

    task automatic test_debounce();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            key[2] = 1'b0; tick(2);
            key[2] = 1'b1; tick(2);
        end
        n_tests++;
        if (a_out !== 4'd0) begin
            n_fail++; $display("FAIL bounce_reject: a_out=%0d want 0", a_out);
        end
        key[2] = 1'b0; tick(10);
        key[2] = 1'b1; tick(10);
        n_tests++;
        if (a_out !== 4'd1) begin
            n_fail++; $display("FAIL debounce_accept: a_out=%0d want 1", a_out);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_b;
        logic [1:0] exp_op;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            press_key(1, 8);
            exp_b = 4'(i % 10);
            n_tests++;
            if (b_out !== exp_b) begin
                n_fail++; $display("FAIL wrap_b[%0d]: b_out=%0d want %0d", i, b_out, exp_b);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            press_key(0, 8);
            exp_op = 2'(i % 4);
            n_tests++;
            if (op_out !== exp_op) begin
                n_fail++; $display("FAIL wrap_op[%0d]: op_out=%0d want %0d", i, op_out, exp_op);
            end
        end
    endtask

    task automatic test_repeat();
        int         ch [4];
        int         nch;
        logic [3:0] prev;
        do_reset();
        for (int i = 0; i < 4; i++) ch[i] = 0;
        nch  = 0;
        prev = a_out;
        key[2] = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick(1);
            if (a_out !== prev) begin
                if (nch < 4) ch[nch] = t;
                nch++;
                prev = a_out;
                if (nch == 4) key[2] = 1'b1;
            end
        end
        key[2] = 1'b1;
        tick(10);
        n_tests++;
        if (nch !== 4) begin
            n_fail++; $display("FAIL repeat_count: pulses=%0d want 4", nch);
        end
        n_tests++;
        if (ch[1] - ch[0] !== 20) begin
            n_fail++; $display("FAIL repeat_delay: gap=%0d want 20", ch[1] - ch[0]);
        end
        n_tests++;
        if ((ch[2] - ch[1] !== 8) || (ch[3] - ch[2] !== 8)) begin
            n_fail++; $display("FAIL repeat_period: gaps=%0d,%0d want 8,8", ch[2] - ch[1], ch[3] - ch[2]);
        end
        n_tests++;
        if (a_out !== 4'd4) begin
            n_fail++; $display("FAIL repeat_value: a_out=%0d want 4", a_out);
        end
    endtask

    task automatic test_commit_once();
        int nreq;
        bit pend;
        nreq = 0;
        pend = 1'b0;
        alu_if.req_ready = 1'b1;
        key[3] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (i == 60) key[3] = 1'b1;
            alu_if.rsp_valid = pend;
            pend = 1'b0;
            if (alu_if.req_valid) begin
                nreq++;
                pend = 1'b1;
                alu_if.rsp_r1 = 4'd7;
                alu_if.rsp_r2 = 4'd1;
            end
        end
        alu_if.rsp_valid = 1'b0;
        alu_if.req_ready = 1'b0;
        tick(2);
        n_tests++;
        if (nreq !== 1) begin
            n_fail++; $display("FAIL commit_no_repeat: requests=%0d want 1", nreq);
        end
        n_tests++;
        if ({res1, res2, res_valid, busy} !== {4'd7, 4'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL commit_result: got r1=%0d r2=%0d v=%0d busy=%0d want 7 1 1 0",
                res1, res2, res_valid, busy);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) press_key(2, 8);
        for (int i = 0; i < 5; i++) press_key(1, 8);
        for (int i = 0; i < 2; i++) press_key(0, 8);
        key[3] = 1'b0;
        wait_req(30, ok);
        key[3] = 1'b1;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL hs_req_timeout: req_valid=%0d want 1", alu_if.req_valid);
        end
        n_tests++;
        if ({alu_if.req_a, alu_if.req_b, alu_if.req_op, busy} !== {4'd3, 4'd5, 2'd2, 1'b1}) begin
            n_fail++; $display("FAIL hs_snapshot: a=%0d b=%0d op=%0d busy=%0d want 3 5 2 1",
                alu_if.req_a, alu_if.req_b, alu_if.req_op, busy);
        end
        press_key(2, 8);
        n_tests++;
        if ({alu_if.req_valid, alu_if.req_a, alu_if.req_b, alu_if.req_op, a_out} !==
            {1'b1, 4'd3, 4'd5, 2'd2, 4'd3}) begin
            n_fail++; $display("FAIL hs_hold: v=%0d a=%0d b=%0d op=%0d a_out=%0d want 1 3 5 2 3",
                alu_if.req_valid, alu_if.req_a, alu_if.req_b, alu_if.req_op, a_out);
        end
        alu_if.req_ready = 1'b1;
        tick(1);
        alu_if.req_ready = 1'b0;
        n_tests++;
        if ({alu_if.req_valid, busy, res_valid} !== 3'b010) begin
            n_fail++; $display("FAIL hs_accept: v=%0d busy=%0d res_valid=%0d want 0 1 0",
                alu_if.req_valid, busy, res_valid);
        end
        alu_if.rsp_r1 = 4'd8;
        alu_if.rsp_r2 = 4'd0;
        alu_if.rsp_valid = 1'b1;
        tick(1);
        alu_if.rsp_valid = 1'b0;
        n_tests++;
        if ({res1, res2, res_valid, busy} !== {4'd8, 4'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL hs_result: r1=%0d r2=%0d v=%0d busy=%0d want 8 0 1 0",
                res1, res2, res_valid, busy);
        end
    endtask

    task automatic test_edit_and_busy_commit();
        bit ok;
        int nreq;
        press_key(1, 8);
        n_tests++;
        if ({b_out, res_valid} !== {4'd6, 1'b0}) begin
            n_fail++; $display("FAIL edit_clears: b_out=%0d res_valid=%0d want 6 0", b_out, res_valid);
        end
        key[3] = 1'b0;
        wait_req(30, ok);
        key[3] = 1'b1;
        alu_if.req_ready = 1'b1;
        tick(10);
        nreq = 0;
        key[3] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (i == 15) key[3] = 1'b1;
            if (alu_if.req_valid) nreq++;
        end
        n_tests++;
        if ({ok, nreq[3:0], busy} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL busy_commit_dropped: ok=%0d extra_req=%0d busy=%0d want 1 0 1",
                ok, nreq, busy);
        end
        alu_if.req_ready = 1'b0;
        alu_if.rsp_r1 = 4'd2;
        alu_if.rsp_r2 = 4'd3;
        alu_if.rsp_valid = 1'b1;
        tick(1);
        alu_if.rsp_r1 = 4'd9;
        tick(1);
        alu_if.rsp_valid = 1'b0;
        n_tests++;
        if ({res1, res2, res_valid, busy} !== {4'd2, 4'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL idle_rsp_ignored: r1=%0d r2=%0d v=%0d busy=%0d want 2 3 1 0",
                res1, res2, res_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        key[3] = 1'b0;
        wait_req(30, ok);
        key[3] = 1'b1;
        alu_if.req_ready = 1'b1;
        tick(1);
        alu_if.req_ready = 1'b0;
        n_tests++;
        if ({ok, busy, alu_if.req_valid} !== 3'b110) begin
            n_fail++; $display("FAIL mid_enter_wait: ok=%0d busy=%0d v=%0d want 1 1 0", ok, busy, alu_if.req_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_out, b_out, op_out, res1, res2, res_valid, busy, alu_if.req_valid,
             alu_if.req_a, alu_if.req_b, alu_if.req_op} !== 31'd0) begin
            n_fail++; $display("FAIL mid_reset_async: a=%0d b=%0d op=%0d r1=%0d v=%0d busy=%0d want all 0",
                a_out, b_out, op_out, res1, res_valid, busy);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        alu_if.rsp_r1 = 4'd5;
        alu_if.rsp_valid = 1'b1;
        tick(1);
        alu_if.rsp_valid = 1'b0;
        tick(1);
        n_tests++;
        if ({res1, res_valid, busy} !== 6'd0) begin
            n_fail++; $display("FAIL mid_late_rsp: r1=%0d v=%0d busy=%0d want 0 0 0", res1, res_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_repeat();
        test_commit_once();
        test_handshake();
        test_edit_and_busy_commit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
